hdmi_timing_gen: RTL and testbench
==================================

Name: hdmi_timing_gen

Overview:
- Parametrised video timing generator for the HDMI output path; successor to the fixed-mode timing block.
- Runs on the pixel clock. Drives VDE and CD to the three TMDS encoders, and drives fetch coordinates to the Tetris pixel renderer.
- Generalised in resolution, sync polarity and renderer pipeline latency.
- Adds HDMI-mode video preamble and guard-band signalling, and frame/line strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks); must be >= 10 when HDMI_MODE=1 (elaboration error otherwise)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- PIPE_LAT, 2, renderer latency in clocks (0..15) from x/y to RGB valid
- HDMI_MODE, 1, 1 = emit preamble/guard, 0 = DVI
- CW, 12, counter width

Ports:
- pixclk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- x  out  CW  fetch column
- y  out  CW  fetch row
- fetch_valid  out  1  x/y inside active area
- VDE  out  1  video data enable, aligned to renderer RGB
- CD  out  2  control data to encoders: CD[0]=hsync, CD[1]=vsync
- ctl  out  4  CTL3..CTL0 for green/red channels
- preamble  out  1  video preamble period
- guard  out  1  video leading guard band
- line_start  out  1  one-clock pulse, first pixel of each active line (VDE-aligned)
- frame_start  out  1  one-clock pulse, first active pixel of frame (VDE-aligned)
- frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Counter h (0..H_TOTAL-1) increments every clock; wraps to 0 and increments v.
- Counter v wraps at V_TOTAL-1 to 0; frame_cnt increments on that same wrap.
- Region order per line and frame: active, front porch, sync, back porch.
- Fetch stage, registered from counter state (1 clock after h/v):
  - x = h, y = v.
  - fetch_valid = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x and y are driven 0 outside the active area.
- Raw controls, computed from the same counter state:
  - hs = HS_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL.
  - vs = VS_POL when v is in the vsync lines, else ~VS_POL; vs changes only at h==0.
- Active-line test: the line following v is active when next_v < V_ACTIVE, where next_v is v+1 with wrap at V_TOTAL.
- Guard: asserted for h in [H_TOTAL-2, H_TOTAL-1] on lines whose next line is active.
- Preamble: asserted for h in [H_TOTAL-10, H_TOTAL-3] on those same lines.
- ctl = 4'b0001 during preamble, else 4'b0000.
- HDMI_MODE=0 forces preamble=0, guard=0 and ctl=0.
- Alignment: VDE, CD, ctl, preamble, guard, line_start and frame_start pass through a PIPE_LAT-deep register delay after the fetch stage.
  - Total latency from counter state to these outputs is 1+PIPE_LAT clocks; x/y latency is 1 clock.
  - Guarantee: VDE rises on the exact clock the renderer presents RGB for x=0.
- line_start = VDE-aligned pulse for h==0 && v<V_ACTIVE.
- frame_start = VDE-aligned pulse for h==0 && v==0.
- Reset (asynchronous):
  - h, v, x, y, frame_cnt and all delay-line contents go to 0.
  - fetch_valid, VDE, ctl, preamble, guard and strobes go to 0.
  - CD = {~VS_POL, ~HS_POL}; delay-line CD stages reset to the same idle value.
  - First clock after reset release begins at h=0, v=0.
- Reset mid-line: all outputs return to reset values immediately; no partial-pulse completion.
- Mutual exclusion (assertion): VDE, preamble and guard are never high together.
- Simultaneous wraps: the h and v wrap on the last clock of a frame produce h=0, v=0 and a frame_cnt increment in the same clock.

Test Plan:
1. Defaults, reset released, run 2 frames → 420000 clocks per frame. frame_start asserted exactly at clocks 3 and 420003 after release; frame_cnt = 2 at end.
2. Defaults, line 0 → VDE high for 640 consecutive clocks. CD[0] low for 96 clocks starting 656 clocks after VDE rises; CD[1] stays 1.
3. Defaults, line 524 (the line before line 0) → preamble high 8 clocks, ctl=4'b0001, then guard high 2 clocks, then VDE rises with no gap. Line 478 shows the same sequence; line 479 shows no preamble.
4. PIPE_LAT=0 vs PIPE_LAT=5, same stimulus → x=0/fetch_valid timing identical. VDE rise shifts by exactly 5 clocks.
5. HDMI_MODE=0, HS_POL=1, VS_POL=1 → preamble, guard and ctl stay 0. Reset value CD=2'b00; hsync pulses high.
6. Assert rst at h=300, v=10 for 3 clocks → outputs go to reset values immediately. After release, counting restarts at h=0, v=0 and frame_cnt=0.

Source files
------------

// File: rtl/hdmi_timing_gen_if.sv
// Timing generator outputs: fetch coordinates to the renderer, controls to the TMDS encoders.
// master = timing generator, slave = renderer/encoder side.
interface hdmi_timing_gen_if #(
    parameter int CW = 12
);
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fetch_valid;
    logic          VDE;
    logic [1:0]    CD;
    logic [3:0]    ctl;
    logic          preamble;
    logic          guard;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;

    modport master (
        output x, y, fetch_valid, VDE, CD, ctl, preamble, guard,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        input  x, y, fetch_valid, VDE, CD, ctl, preamble, guard,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: h/v counters -> fetch x/y (1 clk) and encoder controls (1+PIPE_LAT clks).
// Free-running on pixclk; no backpressure, consumers must keep pace with the pixel clock.
module hdmi_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIPE_LAT  = 2,
    parameter bit HDMI_MODE = 1'b1,
    parameter int CW        = 12
) (
    input  logic               pixclk,
    input  logic               rst,
    hdmi_timing_gen_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int NB      = 7;

    localparam logic [CW-1:0] HA_C    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] PRE_BEG = CW'(H_TOTAL - 10);
    localparam logic [CW-1:0] PRE_END = CW'(H_TOTAL - 3);
    localparam logic [CW-1:0] GRD_BEG = CW'(H_TOTAL - 2);
    localparam logic [CW-1:0] VA_C    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

    localparam logic          HS_IDLE = ~HS_POL;
    localparam logic          VS_IDLE = ~VS_POL;
    // Control word layout: {vde, vsync, hsync, preamble, guard, line_start, frame_start}
    localparam logic [NB-1:0] IDLE    = {1'b0, VS_IDLE, HS_IDLE, 4'b0000};

    if (HDMI_MODE && H_BP < 10) begin : g_chk_bp
        $error("hdmi_timing_gen: H_BP must be >= 10 when HDMI_MODE=1");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_chk_lat
        $error("hdmi_timing_gen: PIPE_LAT must be in 0..15");
    end

    logic [CW-1:0] h_q, h_d, v_q, v_d, nv;
    logic [7:0]    fc_q, fc_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          fv_q;
    logic [NB-1:0] stg_q, stg_d;
    logic          h_wrap, v_last, act, nla, hs, vs, pre, grd;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_last = (v_q == V_LAST);
        nv     = v_last ? '0 : v_q + 1'b1;
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = h_wrap ? nv : v_q;
        fc_d   = (h_wrap && v_last) ? fc_q + 8'd1 : fc_q;

        act    = (h_q < HA_C) && (v_q < VA_C);
        hs     = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : HS_IDLE;
        vs     = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : VS_IDLE;
        // Preamble/guard sit at the tail of the line preceding an active line.
        nla    = (nv < VA_C);
        pre    = HDMI_MODE && nla && (h_q >= PRE_BEG) && (h_q <= PRE_END);
        grd    = HDMI_MODE && nla && (h_q >= GRD_BEG);

        x_d    = act ? h_q : '0;
        y_d    = act ? v_q : '0;
        stg_d  = {act, vs, hs, pre, grd,
                  (h_q == '0) && (v_q < VA_C),
                  (h_q == '0) && (v_q == '0)};
    end

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            fc_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            fv_q  <= 1'b0;
            stg_q <= IDLE;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            fc_q  <= fc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fv_q  <= act;
            stg_q <= stg_d;
        end
    end

    logic [NB-1:0] out_w;

    if (PIPE_LAT == 0) begin : g_nodly
        assign out_w = stg_q;
    end else begin : g_dly
        logic [NB-1:0] dly_q [PIPE_LAT];
        always_ff @(posedge pixclk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= IDLE;
            end else begin
                dly_q[0] <= stg_q;
                for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign out_w = dly_q[PIPE_LAT-1];
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.fetch_valid = fv_q;
    assign vid.VDE         = out_w[6];
    assign vid.CD          = {out_w[5], out_w[4]};
    assign vid.ctl         = {3'b000, out_w[3]};
    assign vid.preamble    = out_w[3];
    assign vid.guard       = out_w[2];
    assign vid.line_start  = out_w[1];
    assign vid.frame_start = out_w[0];
    assign vid.frame_cnt   = fc_q;

    a_excl: assert property (@(posedge pixclk) disable iff (rst)
        $onehot0({vid.VDE, vid.preamble, vid.guard}));
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench: four timing generators (lat 2, lat 0, lat 5, DVI with positive sync) against a
// cycle-index model of the raster; short vertical timing keeps whole frames affordable.
module tb_hdmi_timing_gen;
    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 6, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int NK = 2 * FT + 20;

    localparam int F_VDE = 0, F_PRE = 1, F_GRD = 2, F_FS = 3, F_CD0 = 4, F_CD1 = 5,
                   F_CTL1 = 6, F_CTLNZ = 7, F_FV = 8;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        fv;
        logic        vde;
        logic [1:0]  cd;
        logic [3:0]  ctl;
        logic        pre;
        logic        grd;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_timing_gen_if #(.CW(12)) if0 ();
    hdmi_timing_gen_if #(.CW(12)) if1 ();
    hdmi_timing_gen_if #(.CW(12)) if2 ();
    hdmi_timing_gen_if #(.CW(12)) if3 ();

    hdmi_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(2))
        u0 (.pixclk(clk), .rst(rst), .vid(if0));
    hdmi_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(0))
        u1 (.pixclk(clk), .rst(rst), .vid(if1));
    hdmi_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(5))
        u2 (.pixclk(clk), .rst(rst), .vid(if2));
    hdmi_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(2),
                      .HDMI_MODE(1'b0), .HS_POL(1'b1), .VS_POL(1'b1))
        u3 (.pixclk(clk), .rst(rst), .vid(if3));

    obs_t obs [4];
    assign obs[0] = {if0.x, if0.y, if0.fetch_valid, if0.VDE, if0.CD, if0.ctl, if0.preamble,
                     if0.guard, if0.line_start, if0.frame_start, if0.frame_cnt};
    assign obs[1] = {if1.x, if1.y, if1.fetch_valid, if1.VDE, if1.CD, if1.ctl, if1.preamble,
                     if1.guard, if1.line_start, if1.frame_start, if1.frame_cnt};
    assign obs[2] = {if2.x, if2.y, if2.fetch_valid, if2.VDE, if2.CD, if2.ctl, if2.preamble,
                     if2.guard, if2.line_start, if2.frame_start, if2.frame_cnt};
    assign obs[3] = {if3.x, if3.y, if3.fetch_valid, if3.VDE, if3.CD, if3.ctl, if3.preamble,
                     if3.guard, if3.line_start, if3.frame_start, if3.frame_cnt};

    int lat_c [4]  = '{2, 0, 5, 2};
    bit hdmi_c [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit pol_c [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

    obs_t hist [4][NK+1];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   rec = 1'b1;

    // Expected outputs k clocks after reset release, derived from raster position alone.
    function automatic obs_t model(int kk, int lat, bit hdmi, bit pol);
        obs_t e;
        int   n, h, v, nl;
        e    = '0;
        e.cd = {~pol, ~pol};
        n = kk - 1;
        if (n >= 0) begin
            h = n % HT;
            v = (n / HT) % VT;
            if (h < HA && v < VA) begin
                e.x  = 12'(h);
                e.y  = 12'(v);
                e.fv = 1'b1;
            end
        end
        n = kk - 1 - lat;
        if (n >= 0) begin
            h  = n % HT;
            v  = (n / HT) % VT;
            nl = (v + 1) % VT;
            e.vde   = (h < HA) && (v < VA);
            e.cd[0] = (h >= HA + HF && h < HA + HF + HSW) ? pol : ~pol;
            e.cd[1] = (v >= VA + VF && v < VA + VF + VSW) ? pol : ~pol;
            e.pre   = hdmi && (nl < VA) && (h >= HT - 10) && (h <= HT - 3);
            e.grd   = hdmi && (nl < VA) && (h >= HT - 2);
            e.ctl   = e.pre ? 4'b0001 : 4'b0000;
            e.ls    = (h == 0) && (v < VA);
            e.fs    = (h == 0) && (v == 0);
        end
        e.fc = 8'((kk / FT) % 256);
        return e;
    endfunction

    function automatic logic fld(obs_t o, int w);
        case (w)
            F_VDE:   return o.vde;
            F_PRE:   return o.pre;
            F_GRD:   return o.grd;
            F_FS:    return o.fs;
            F_CD0:   return o.cd[0];
            F_CD1:   return o.cd[1];
            F_CTL1:  return o.ctl == 4'b0001;
            F_CTLNZ: return |o.ctl;
            F_FV:    return o.fv;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int cnt(int d, int lo, int hi, int w);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (fld(hist[d][i], w)) c++;
        return c;
    endfunction

    function automatic int run_len(int d, int s, int w, logic val);
        int c = 0;
        for (int i = s; i <= NK; i++) begin
            if (fld(hist[d][i], w) !== val) break;
            c++;
        end
        return c;
    endfunction

    function automatic int first(int d, int w);
        for (int i = 0; i <= NK; i++) if (fld(hist[d][i], w)) return i;
        return -1;
    endfunction

    task automatic chk(string tag, int obsv, int expv);
        checks++;
        assert (obsv === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obsv, expv);
        end
    endtask

    task automatic check_cycle();
        obs_t e;
        for (int d = 0; d < 4; d++) begin
            e = model(k, lat_c[d], hdmi_c[d], pol_c[d]);
            checks++;
            assert (obs[d] === e) else begin
                errors++;
                $error("FAIL cycle dut%0d k=%0d observed=%h expected=%h", d, k, obs[d], e);
            end
            if (rec && k <= NK) hist[d][k] = obs[d];
        end
        checks++;
        assert ($onehot0({obs[0].vde, obs[0].pre, obs[0].grd}) === 1'b1) else begin
            errors++;
            $error("FAIL excl k=%0d observed=%b expected=onehot0", k,
                   {obs[0].vde, obs[0].pre, obs[0].grd});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check_cycle();
    endtask

    task automatic pulse_reset(int hold);
        rst = 1'b1;
        #1;
        k = 0;
        check_cycle();
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        int kl [2];
        int ka, n;

        repeat (3) @(posedge clk);
        #1;
        k = 0;
        check_cycle();
        chk("rst_cd", int'(obs[0].cd), 3);
        chk("rst_fc", int'(obs[0].fc), 0);
        rst = 1'b0;
        while (k < NK) step();

        // Two frames: frame_start placement and frame counter
        chk("fs_at_3", int'(hist[0][3].fs), 1);
        chk("fs_at_3_plus_frame", int'(hist[0][3 + FT].fs), 1);
        chk("fs_count_2frames", cnt(0, 0, 2 * FT, F_FS), 2);
        chk("fc_after_2frames", int'(hist[0][2 * FT].fc), 2);

        // Line 0: VDE run, hsync position/width, vsync idle
        chk("vde_low_before", cnt(0, 0, 2, F_VDE), 0);
        chk("vde_run_line0", run_len(0, 3, F_VDE, 1'b1), HA);
        chk("hs_high_before", cnt(0, 3, 3 + HA + HF - 1, F_CD0), HA + HF);
        chk("hs_low_run", run_len(0, 3 + HA + HF, F_CD0, 1'b0), HSW);
        chk("vs_idle_line0", cnt(0, 3, 3 + HT - 1, F_CD1), HT);

        // Preamble then guard then VDE, before frame line 0 and before the last active line
        kl[0] = 3 + FT;
        kl[1] = 3 + (VA - 1) * HT;
        for (int i = 0; i < 2; i++) begin
            chk("pre_len", cnt(0, kl[i] - 10, kl[i] - 3, F_PRE), 8);
            chk("pre_ctl", cnt(0, kl[i] - 10, kl[i] - 3, F_CTL1), 8);
            chk("pre_before", int'(hist[0][kl[i] - 11].pre), 0);
            chk("grd_len", cnt(0, kl[i] - 2, kl[i] - 1, F_GRD), 2);
            chk("grd_no_pre", cnt(0, kl[i] - 2, kl[i] - 1, F_PRE), 0);
            chk("vde_gap", cnt(0, kl[i] - 10, kl[i] - 1, F_VDE), 0);
            chk("vde_after_grd", int'(hist[0][kl[i]].vde), 1);
        end
        ka = 3 + VA * HT;
        chk("no_pre_last_line", cnt(0, ka - 10, ka - 3, F_PRE), 0);
        chk("no_grd_last_line", cnt(0, ka - 2, ka - 1, F_GRD), 0);

        // Renderer latency only moves the encoder-side outputs
        chk("fv_first_lat0", first(1, F_FV), 1);
        chk("fv_first_lat5", first(2, F_FV), 1);
        chk("vde_first_lat0", first(1, F_VDE), 1);
        chk("vde_shift_lat5", first(2, F_VDE) - first(1, F_VDE), 5);

        // DVI mode with positive sync
        chk("dvi_rst_cd", int'(hist[3][0].cd), 0);
        chk("dvi_pre", cnt(3, 0, NK, F_PRE), 0);
        chk("dvi_grd", cnt(3, 0, NK, F_GRD), 0);
        chk("dvi_ctl", cnt(3, 0, NK, F_CTLNZ), 0);
        chk("dvi_hs_high_run", run_len(3, 3 + HA + HF, F_CD0, 1'b1), HSW);

        // Reset in the middle of line 10 (h=300)
        rec = 1'b0;
        while (k < 2 * FT + 10 * HT + 300) step();
        #1;
        pulse_reset(3);
        chk("midrst_cd", int'(obs[0].cd), 3);
        chk("midrst_fc", int'(obs[0].fc), 0);
        repeat (3) step();
        chk("restart_fs", int'(obs[0].fs), 1);
        chk("restart_fc", int'(obs[0].fc), 0);
        repeat (1000) step();

        // Random reset points and hold lengths
        repeat (6) begin
            n = $urandom_range(20, 2500);
            repeat (n) step();
            #($urandom_range(1, 3));
            pulse_reset($urandom_range(1, 3));
        end
        repeat (900) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
